// File: rtl/db_event_arbiter.sv
// Multi-channel debounced button front end with a round-robin press-event port.
// Optional sticky overrun flags are enabled with `define DB_EVT_OVERRUN_EN.
module db_event_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TICK_PERIOD = 2_000_000,
  parameter int unsigned DB_TICKS    = 4,
  localparam int unsigned CHW        = $clog2(NUM_CH),
  localparam int unsigned CNTW       = $clog2(DB_TICKS + 1),
  localparam int unsigned PW         = $clog2(TICK_PERIOD)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_sw,
  output logic [NUM_CH-1:0] o_sw_debounced,
  output logic              o_evt_valid,
  output logic [CHW-1:0]    o_evt_ch,
  input  logic              i_evt_ready,
  output logic [NUM_CH-1:0] o_pending
`ifdef DB_EVT_OVERRUN_EN
  ,
  output logic [NUM_CH-1:0] o_overrun,
  input  logic              i_ovr_clr
`endif
);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_e;

  logic [NUM_CH-1:0] sw_meta_q, sw_s_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNTW-1:0]   cnt_q   [NUM_CH];
  logic [CNTW-1:0]   cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] deb_q, deb_d;

  logic [NUM_CH-1:0] pending_q, pending_d, clr;
  logic              valid_q, valid_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic [CHW-1:0]    sel;
  logic              found, load;
  int unsigned       idx;

  assign tick = (presc_q == '0);

  always_comb begin
    presc_d = tick ? PW'(TICK_PERIOD - 1) : presc_q - PW'(1);
  end

  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ZERO: begin
          if (sw_s_q[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = CNTW'(DB_TICKS - 1);
          end
        end
        WAIT1: begin
          if (!sw_s_q[i]) begin
            state_d[i] = ZERO;
          end else if (tick) begin
            if (cnt_q[i] == '0) begin
              state_d[i] = ONE;
              rise[i]    = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
          end
        end
        ONE: begin
          if (!sw_s_q[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = CNTW'(DB_TICKS - 1);
          end
        end
        WAIT0: begin
          if (sw_s_q[i]) begin
            state_d[i] = ONE;
          end else if (tick) begin
            if (cnt_q[i] == '0) begin
              state_d[i] = ZERO;
            end else begin
              cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
          end
        end
        default: state_d[i] = ZERO;
      endcase
      // Registered from the next state so it lines up with the pending bit.
      deb_d[i] = (state_d[i] == ONE) || (state_d[i] == WAIT0);
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(ptr_q) + k) % NUM_CH;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        sel   = CHW'(idx);
      end
    end
  end

  always_comb begin
    load = (!valid_q || i_evt_ready) && found;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      clr[i] = load && (sel == CHW'(i));
    end
    // A rise on a channel being loaded this cycle re-arms it.
    pending_d = (pending_q & ~clr) | rise;
    valid_d   = load || (valid_q && !i_evt_ready);
    ch_d      = load ? sel : ch_q;
    ptr_d     = load ? sel : ptr_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      presc_q   <= PW'(TICK_PERIOD - 1);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ZERO;
        cnt_q[i]   <= '0;
      end
      deb_q     <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      ptr_q     <= CHW'(NUM_CH - 1);
    end else begin
      sw_meta_q <= i_sw;
      sw_s_q    <= sw_meta_q;
      presc_q   <= presc_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      deb_q     <= deb_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef DB_EVT_OVERRUN_EN
  logic [NUM_CH-1:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = (i_ovr_clr ? '0 : ovr_q) | (rise & pending_q & ~clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ovr_q <= '0;
    else          ovr_q <= ovr_d;
  end

  assign o_overrun = ovr_q;
`endif

  assign o_sw_debounced = deb_q;
  assign o_pending      = pending_q;
  assign o_evt_valid    = valid_q;
  assign o_evt_ch       = ch_q;

endmodule

// File: tb/tb_db_event_arbiter.sv
// Scoreboard bench for db_event_arbiter (TICK_PERIOD=4, DB_TICKS=3, NUM_CH=4).
module tb_db_event_arbiter;
  localparam int NUM_CH = 4;
  localparam int TP     = 4;
  localparam int DBT    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] sw = '0;
  logic [NUM_CH-1:0] deb;
  logic              valid;
  logic [1:0]        ch;
  logic              ready = 1'b0;
  logic [NUM_CH-1:0] pending;
`ifdef DB_EVT_OVERRUN_EN
  logic [NUM_CH-1:0] overrun;
  logic              ovr_clr = 1'b0;
`endif

  db_event_arbiter #(
    .NUM_CH(NUM_CH),
    .TICK_PERIOD(TP),
    .DB_TICKS(DBT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_sw(sw),
    .o_sw_debounced(deb),
    .o_evt_valid(valid),
    .o_evt_ch(ch),
    .i_evt_ready(ready),
    .o_pending(pending)
`ifdef DB_EVT_OVERRUN_EN
    ,
    .o_overrun(overrun),
    .i_ovr_clr(ovr_clr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = rst_n ? cyc + 1 : 0;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    int e;
    if (rst_n && valid && ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      check_eq("evt_ch", ch, e);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_deb(input int c, input logic lvl, input string tag);
    int k = 0;
    while (deb[c] !== lvl && k < 200) begin
      step();
      k++;
    end
    check_eq(tag, deb[c], lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c, n, exp_cyc, k;
    logic flag;

    step(2);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_deb", deb, 0);
    check_eq("rst_ch", ch, 0);
    rst_n = 1'b1;

    // Clean press on ch1; expected confirm cycle derived from the tick schedule
    sw[1] = 1'b1;
    c0 = cyc;
    exp_q.push_back(1);
    c = c0 + 3;
    n = 0;
    while (n < DBT) begin
      if (c % TP == TP - 1) n++;
      if (n < DBT) c++;
    end
    exp_cyc = c + 1;
    k = 0;
    while (!deb[1] && k < 100) begin
      step();
      k++;
    end
    check_eq("press_deb_cyc", cyc, exp_cyc);
    check_eq("press_pend", pending[1], 1);
    check_eq("press_valid_early", valid, 0);
    step();
    check_eq("press_valid", valid, 1);
    check_eq("press_ch", ch, 1);
    check_eq("press_pend_clr", pending, 0);
    step(3);
    check_eq("press_hold_valid", valid, 1);
    check_eq("press_hold_ch", ch, 1);
    ready = 1'b1;
    step();
    check_eq("press_accept_drop", valid, 0);
    ready = 1'b0;
    sw[1] = 1'b0;
    wait_deb(1, 1'b0, "press_release_deb");
    step(3);
    check_eq("press_release_noevt", valid, 0);

    // Bounce on ch0, then settle high
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw[0] = ~sw[0];
      step();
    end
    check_eq("bounce_deb", deb[0], 0);
    check_eq("bounce_pend", pending[0], 0);
    sw[0] = 1'b1;
    exp_q.push_back(0);
    wait_deb(0, 1'b1, "bounce_settle_deb");
    step(3);
    check_eq("bounce_done_valid", valid, 0);

    // Release glitch of one tick, then a real release
    flag = 1'b1;
    sw[0] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) sw[0] = 1'b1;
      step();
      flag = flag & deb[0];
    end
    check_eq("rel_glitch_deb", flag, 1);
    sw[0] = 1'b0;
    wait_deb(0, 1'b0, "rel_long_deb");
    step(5);
    check_eq("rel_long_valid", valid, 0);
    check_eq("rel_long_pend", pending, 0);

    // Overrun on ch2 while its first event is held
    ready = 1'b0;
    sw[2] = 1'b1;
    exp_q.push_back(2);
    wait_deb(2, 1'b1, "ovr_p1_deb");
    step();
    check_eq("ovr_p1_valid", valid, 1);
    check_eq("ovr_p1_ch", ch, 2);
    sw[2] = 1'b0;
    wait_deb(2, 1'b0, "ovr_r1_deb");
    sw[2] = 1'b1;
    exp_q.push_back(2);
    wait_deb(2, 1'b1, "ovr_p2_deb");
    step();
    check_eq("ovr_p2_pend", pending, 4'b0100);
    sw[2] = 1'b0;
    wait_deb(2, 1'b0, "ovr_r2_deb");
    sw[2] = 1'b1;
    wait_deb(2, 1'b1, "ovr_p3_deb");
    step();
    check_eq("ovr_p3_pend", pending, 4'b0100);
    check_eq("ovr_p3_ch", ch, 2);
`ifdef DB_EVT_OVERRUN_EN
    check_eq("ovr_flag_set", overrun, 4'b0100);
`endif
    ready = 1'b1;
    step(4);
    ready = 1'b0;
    check_eq("ovr_drained", valid, 0);
`ifdef DB_EVT_OVERRUN_EN
    check_eq("ovr_flag_sticky", overrun, 4'b0100);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check_eq("ovr_flag_clr", overrun, 0);
`endif
    sw[2] = 1'b0;
    wait_deb(2, 1'b0, "ovr_r3_deb");

    // Reset in the middle of a held event with two more pending
    sw[2] = 1'b1;
    wait_deb(2, 1'b1, "mid_p_deb");
    step();
    sw[1] = 1'b1;
    sw[3] = 1'b1;
    wait_deb(1, 1'b1, "mid_p13_deb");
    step();
    check_eq("mid_pend", pending, 4'b1010);
    check_eq("mid_valid", valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_pend", pending, 0);
    check_eq("mid_rst_deb", deb, 0);
    check_eq("mid_rst_ch", ch, 0);
    sw = '0;
    step(2);
    rst_n = 1'b1;
    ready = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      flag = flag | valid;
    end
    check_eq("mid_post_noevt", flag, 0);

    // Round robin: ch0, ch2, ch3 pending together, pointer fresh from reset
    ready = 1'b0;
    sw = 4'b1101;
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(3);
    wait_deb(0, 1'b1, "rr_deb");
    check_eq("rr_pend", pending, 4'b1101);
    step();
    check_eq("rr_first_valid", valid, 1);
    check_eq("rr_first_ch", ch, 0);
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      flag = flag & (valid === 1'b1) & (ch === 2'd0);
    end
    check_eq("rr_hold", flag, 1);
    ready = 1'b1;
    step();
    check_eq("rr_v1", valid, 1);
    step();
    check_eq("rr_v2", valid, 1);
    step();
    check_eq("rr_end", valid, 0);
    sw = '0;
    wait_deb(0, 1'b0, "rr_release_deb");
    step(5);
    check_eq("sb_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/db_event_arbiter.md
Name: db_event_arbiter

Overview:
- Multi-channel button front end: NUM_CH raw switch inputs share one tick prescaler.
- Each channel has its own 4-state debounce FSM.
- Confirmed press (rising) events are queued as pending bits. A round-robin arbiter presents them one at a time on a valid/ready event port.
- Sits between board buttons and the command/UI logic, which consumes one press event at a time.

Parameters:
- NUM_CH, 4, number of switch channels (2..16).
- TICK_PERIOD, 2_000_000, clock cycles per shared sample tick (>=2).
- DB_TICKS, 4, consecutive stable ticks required to confirm a level change (>=1).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sw  in  NUM_CH  raw, asynchronous switch levels.
- o_sw_debounced  out  NUM_CH  debounced levels.
- o_evt_valid  out  1  press event held on output.
- o_evt_ch  out  $clog2(NUM_CH)  channel index of held event.
- i_evt_ready  in  1  consumer accepts event when high with o_evt_valid.
- o_pending  out  NUM_CH  pending event bits (debug/status).

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low (i_rst_n). While low, all state clears immediately: FSMs to ZERO, counters 0, o_sw_debounced=0, o_pending=0, o_evt_valid=0, o_evt_ch=0, round-robin pointer=NUM_CH-1 (channel 0 is searched first). Reset asserted mid-debounce or mid-handshake discards everything; no event survives reset.
- Synchronizer: each i_sw bit passes through a 2-flop synchronizer (sw_s). FSMs see only sw_s, 2 cycles after the input.
- Prescaler: down-counter loaded with TICK_PERIOD-1, decrements every cycle. When it is 0, tick=1 for that one cycle and the counter reloads. It is free-running and shared by all channels. The first tick after reset is at cycle TICK_PERIOD-1.
- Per-channel FSM, states ZERO, WAIT1, ONE, WAIT0, with a cnt of width $clog2(DB_TICKS+1):
  - ZERO: sw_s=1 -> WAIT1, cnt=DB_TICKS-1.
  - WAIT1: sw_s=0 on any cycle -> ZERO. If tick and sw_s=1: when cnt==0 -> ONE and assert rise for one cycle; otherwise cnt--.
  - ONE: o_sw_debounced=1. sw_s=0 -> WAIT0, cnt=DB_TICKS-1.
  - WAIT0: o_sw_debounced=1. sw_s=1 on any cycle -> ONE. If tick and sw_s=0: when cnt==0 -> ZERO; otherwise cnt--.
  - Illegal encoding -> ZERO.
  - o_sw_debounced is registered: it goes high the cycle after the ONE transition, which is the same cycle the pending bit sets.
- Pending: rise[i] sets pending[i] on the next edge. A load into the output slot clears pending[i]. If set and clear hit the same channel in the same cycle, set wins and pending stays 1.
- A rise while pending[i] is already 1 is dropped (see Optional Feature).
- Output slot: the slot is free when o_evt_valid=0, or when o_evt_valid and i_evt_ready are both high (accept).
  - If the slot is free and any pending bit is set, the arbiter loads one event:
    - Selects the first set bit searching ptr+1, ptr+2, ... modulo NUM_CH.
    - Registers o_evt_ch=i and o_evt_valid=1, sets ptr=i, clears pending[i].
  - Accept with nothing pending -> o_evt_valid=0 next cycle.
  - Back-to-back: accept plus pending gives a new event the next cycle, so o_evt_valid stays high.
- Latency:
  - pending set -> o_evt_valid one cycle later, if the slot was empty.
  - o_evt_valid and o_evt_ch are stable while i_evt_ready=0; valid never drops without an accept.
- Releases generate no events.

Optional Feature:
- Macro: DB_EVT_OVERRUN_EN.
- Defined:
  - Adds ports o_overrun (out, NUM_CH) and i_ovr_clr (in, 1).
  - o_overrun[i] is set sticky when rise[i] occurs while pending[i]=1 and pending[i] is not being cleared that cycle.
  - i_ovr_clr=1 clears all overrun bits; a set in the same cycle wins.
  - Reset value 0.
- Undefined: the ports are absent and overrun rises are silently dropped.

Test Plan (TICK_PERIOD=4, DB_TICKS=3, NUM_CH=4):
- Clean press: i_sw[1] held high.
  - o_sw_debounced[1] rises on the 3rd tick after sw_s[1]=1, plus 1 cycle; pending[1] rises the same cycle.
  - o_evt_valid=1 with o_evt_ch=1 one cycle later.
  - With ready=1 the event is accepted and valid drops the next cycle.
- Bounce: i_sw[0] toggles every 3 cycles for 40 cycles, then settles high -> no event during bouncing; exactly one event after 3 stable ticks.
- Release bounce: channel in ONE, i_sw low for 1 tick then high -> o_sw_debounced stays 1 and no event. Low for 3 ticks -> o_sw_debounced=0 and no event.
- Round-robin: pending bits for ch 0, 2, 3 all set with ready=0 -> ch0 is presented and held stable for 10 cycles. Ready then held at 1 -> valid stays high continuously; o_evt_ch sequence 0, 2, 3; then valid drops.
- Overrun: ch2 pressed twice while ready=0 and its first event is held, with a third press before acceptance -> exactly 2 ch2 events delivered. With DB_EVT_OVERRUN_EN, o_overrun[2]=1 until i_ovr_clr pulses.
- Reset mid-operation: assert i_rst_n=0 while o_evt_valid=1 with pending=4'b1010 -> all outputs 0 asynchronously. After release, no event appears unless a new press is confirmed.
